// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared enums, funct/opcode codes and flag bit positions for the execute stage.
// Rev 1.0
`default_nettype none

package alu_exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_RTYPE = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SLT   = 4'd6,
    OP_SLTU  = 4'd7,
    OP_LUI   = 4'd8
  } alu_op_e;

  typedef enum logic [3:0] {
    CTRL_AND  = 4'h0,
    CTRL_ADD  = 4'h1,
    CTRL_SUB  = 4'h2,
    CTRL_OR   = 4'h3,
    CTRL_XOR  = 4'h4,
    CTRL_NOR  = 4'h5,
    CTRL_SLT  = 4'h6,
    CTRL_SLTU = 4'h7,
    CTRL_SLL  = 4'h8,
    CTRL_SRL  = 4'h9,
    CTRL_SRA  = 4'hA,
    CTRL_LUI  = 4'hB
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    COND_NEVER  = 4'd0,
    COND_ALWAYS = 4'd1,
    COND_EQ     = 4'd2,
    COND_NE     = 4'd3,
    COND_LT     = 4'd4,
    COND_GE     = 4'd5,
    COND_LE     = 4'd6,
    COND_GT     = 4'd7
  } cond_e;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  localparam logic [5:0] OPC_REGIMM = 6'h01;
  localparam logic [5:0] OPC_BEQ    = 6'h04;
  localparam logic [5:0] OPC_BNE    = 6'h05;
  localparam logic [5:0] OPC_BLEZ   = 6'h06;
  localparam logic [5:0] OPC_BGTZ   = 6'h07;

  localparam int FLAG_Z   = 0;
  localparam int FLAG_N   = 1;
  localparam int FLAG_C   = 2;
  localparam int FLAG_V   = 3;
  localparam int FLAG_SLT = 4;
  localparam int FLAG_ULT = 5;

endpackage

`default_nettype wire

// File: rtl/alu_exec_core.sv
// alu_exec_core: combinational ALU producing result C and flags {2'b0,ULT,SLT,V,C,N,Z}.
// Rev 1.0
`default_nettype none

module alu_exec_core
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic [7:0]      flags
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;
  logic [4:0]    shamt;
  logic          add_v;
  logic          sub_v;
  logic          slt_f;
  logic          borrow;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign borrow = diff[XLEN];
  assign shamt  = a[4:0];
  assign add_v  = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
  assign sub_v  = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
  assign slt_f  = diff[XLEN-1] ^ sub_v;

  always_comb begin
    result = '0;
    case (ctrl)
      CTRL_AND:  result = a & b;
      CTRL_ADD:  result = sum[XLEN-1:0];
      CTRL_SUB:  result = diff[XLEN-1:0];
      CTRL_OR:   result = a | b;
      CTRL_XOR:  result = a ^ b;
      CTRL_NOR:  result = ~(a | b);
      CTRL_SLT:  result = {{(XLEN-1){1'b0}}, slt_f};
      CTRL_SLTU: result = {{(XLEN-1){1'b0}}, borrow};
      CTRL_SLL:  result = b << shamt;
      CTRL_SRL:  result = b >> shamt;
      CTRL_SRA:  result = $signed(b) >>> shamt;
      CTRL_LUI:  result = b << 16;
      default:   result = '0;
    endcase
  end

  // Carry/overflow follow the adder only for ADD; every other function reports A-B.
  always_comb begin
    flags           = '0;
    flags[FLAG_Z]   = (result == '0);
    flags[FLAG_N]   = result[XLEN-1];
    flags[FLAG_C]   = (ctrl == CTRL_ADD) ? sum[XLEN] : ~borrow;
    flags[FLAG_V]   = (ctrl == CTRL_ADD) ? add_v : sub_v;
    flags[FLAG_SLT] = slt_f;
    flags[FLAG_ULT] = borrow;
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage - ALU control decode, ALU, branch/jump resolution, registered flags.
// Optional overflow trap enabled by macro ALU_EXEC_OVF_TRAP_EN. Rev 1.0
`default_nettype none

module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic [31:0]     inst,
  input  logic [3:0]      alu_op,
  input  logic            branch,
  input  logic            jump,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] alu_result,
  output logic [7:0]      flags,
  output logic [7:0]      flags_q,
  output logic [3:0]      alu_ctrl,
  output logic            shift,
  output logic            reg_to_pc,
  output logic            reg_pc_wr,
  output logic [3:0]      cond,
  output logic            branch_tk,
  output logic            jump_tk,
  output logic            ovf_trap,
  output logic            ovf_sticky
);

  logic [5:0]      funct;
  logic [5:0]      opcode;
  alu_ctrl_e       ctrl;
  cond_e           cond_sel;
  logic            cond_true;
  logic            addsub_trap_op;
  logic [XLEN-1:0] a_eff;
  logic            unused_inst;

  assign funct       = inst[5:0];
  assign opcode      = inst[31:26];
  assign unused_inst = ^{inst[25:17], inst[15:11]};

  always_comb begin
    ctrl           = CTRL_ADD;
    shift          = 1'b0;
    reg_to_pc      = 1'b0;
    reg_pc_wr      = 1'b0;
    addsub_trap_op = 1'b0;
    case (alu_op)
      OP_ADD:  ctrl = CTRL_ADD;
      OP_SUB:  ctrl = CTRL_SUB;
      OP_AND:  ctrl = CTRL_AND;
      OP_OR:   ctrl = CTRL_OR;
      OP_XOR:  ctrl = CTRL_XOR;
      OP_SLT:  ctrl = CTRL_SLT;
      OP_SLTU: ctrl = CTRL_SLTU;
      OP_LUI:  ctrl = CTRL_LUI;
      OP_RTYPE: begin
        case (funct)
          FUNCT_SLL:  begin ctrl = CTRL_SLL; shift = 1'b1; end
          FUNCT_SRL:  begin ctrl = CTRL_SRL; shift = 1'b1; end
          FUNCT_SRA:  begin ctrl = CTRL_SRA; shift = 1'b1; end
          FUNCT_SLLV: ctrl = CTRL_SLL;
          FUNCT_SRLV: ctrl = CTRL_SRL;
          FUNCT_SRAV: ctrl = CTRL_SRA;
          FUNCT_JR:   reg_to_pc = 1'b1;
          FUNCT_JALR: begin reg_to_pc = 1'b1; reg_pc_wr = 1'b1; end
          FUNCT_ADD:  begin ctrl = CTRL_ADD; addsub_trap_op = 1'b1; end
          FUNCT_ADDU: ctrl = CTRL_ADD;
          FUNCT_SUB:  begin ctrl = CTRL_SUB; addsub_trap_op = 1'b1; end
          FUNCT_SUBU: ctrl = CTRL_SUB;
          FUNCT_AND:  ctrl = CTRL_AND;
          FUNCT_OR:   ctrl = CTRL_OR;
          FUNCT_XOR:  ctrl = CTRL_XOR;
          FUNCT_NOR:  ctrl = CTRL_NOR;
          FUNCT_SLT:  ctrl = CTRL_SLT;
          FUNCT_SLTU: ctrl = CTRL_SLTU;
          default:    ctrl = CTRL_ADD;
        endcase
      end
      default: ctrl = CTRL_ADD;
    endcase
  end

  assign alu_ctrl = ctrl;
  assign a_eff    = shift ? {{(XLEN-5){1'b0}}, inst[10:6]} : op_a;

  alu_exec_core #(
    .XLEN (XLEN)
  ) u_core (
    .ctrl   (ctrl),
    .a      (a_eff),
    .b      (op_b),
    .result (alu_result),
    .flags  (flags)
  );

  assign jump_tk = jump | reg_to_pc;

  always_comb begin
    cond_sel = COND_NEVER;
    if (jump_tk) begin
      cond_sel = COND_ALWAYS;
    end else begin
      case (opcode)
        OPC_BEQ:    cond_sel = COND_EQ;
        OPC_BNE:    cond_sel = COND_NE;
        OPC_BLEZ:   cond_sel = COND_LE;
        OPC_BGTZ:   cond_sel = COND_GT;
        OPC_REGIMM: cond_sel = inst[16] ? COND_GE : COND_LT;
        default:    cond_sel = COND_NEVER;
      endcase
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      COND_ALWAYS: cond_true = 1'b1;
      COND_EQ:     cond_true = flags[FLAG_Z];
      COND_NE:     cond_true = ~flags[FLAG_Z];
      COND_LT:     cond_true = flags[FLAG_SLT];
      COND_GE:     cond_true = ~flags[FLAG_SLT];
      COND_LE:     cond_true = flags[FLAG_SLT] | flags[FLAG_Z];
      COND_GT:     cond_true = ~flags[FLAG_SLT] & ~flags[FLAG_Z];
      default:     cond_true = 1'b0;
    endcase
  end

  assign cond      = cond_sel;
  assign branch_tk = branch & cond_true & ~jump_tk;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags;
    end
  end

`ifdef ALU_EXEC_OVF_TRAP_EN
  logic rst_q;
  logic sticky_q;

  // rst_q masks the trap for the first cycle after reset release.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rst_q    <= 1'b1;
      sticky_q <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      if (ovf_trap) begin
        sticky_q <= 1'b1;
      end
    end
  end

  assign ovf_trap   = flags[FLAG_V] & addsub_trap_op & ~rst_q;
  assign ovf_sticky = sticky_q;
`else
  logic unused_trap;
  assign unused_trap = addsub_trap_op;
  assign ovf_trap    = 1'b0;
  assign ovf_sticky  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit with hand-computed expectations.
// Rev 1.0
`default_nettype none

module tb_alu_exec_unit;

`ifdef ALU_EXEC_OVF_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic        CLK;
  logic        rst_n;
  logic [31:0] inst;
  logic [3:0]  alu_op;
  logic        branch;
  logic        jump;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic [7:0]  flags;
  logic [7:0]  flags_q;
  logic [3:0]  alu_ctrl;
  logic        shift;
  logic        reg_to_pc;
  logic        reg_pc_wr;
  logic [3:0]  cond;
  logic        branch_tk;
  logic        jump_tk;
  logic        ovf_trap;
  logic        ovf_sticky;

  int passed = 0;
  int total  = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .inst       (inst),
    .alu_op     (alu_op),
    .branch     (branch),
    .jump       (jump),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_result (alu_result),
    .flags      (flags),
    .flags_q    (flags_q),
    .alu_ctrl   (alu_ctrl),
    .shift      (shift),
    .reg_to_pc  (reg_to_pc),
    .reg_pc_wr  (reg_pc_wr),
    .cond       (cond),
    .branch_tk  (branch_tk),
    .jump_tk    (jump_tk),
    .ovf_trap   (ovf_trap),
    .ovf_sticky (ovf_sticky)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] shamt, input logic [5:0] fn);
    return {6'h00, 15'd0, shamt, fn};
  endfunction

  task automatic drive(input logic [31:0] i, input logic [3:0] op, input logic br,
                       input logic jp, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    inst = i; alu_op = op; branch = br; jump = jp; op_a = a; op_b = b;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; inst = '0; alu_op = '0; branch = 1'b0; jump = 1'b0; op_a = '0; op_b = '0;
    #2;
    chk("reset_flags_q", 32'(flags_q), 32'h00);
    chk("reset_sticky", 32'(ovf_sticky), 32'h0);
    chk("reset_live_flags", 32'(flags), 32'h01);
    #10 rst_n = 1'b1;
    repeat (2) @(posedge CLK);

    // ADD with carry out, no overflow
    drive(32'h0, 4'd0, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD);
    chk("add_result", alu_result, 32'd4);
    chk("add_flags", 32'(flags), 32'h24);
    chk("add_ctrl", 32'(alu_ctrl), 32'h1);
    chk("add_cond", 32'(cond), 32'h0);
    @(posedge CLK); #1;
    chk("add_flags_q", 32'(flags_q), 32'h24);

    // beq taken / not taken, bne
    drive({6'h04, 26'd0}, 4'd1, 1'b1, 1'b0, 32'd5, 32'd5);
    chk("beq_result", alu_result, 32'd0);
    chk("beq_flags", 32'(flags), 32'h05);
    chk("beq_cond", 32'(cond), 32'd2);
    chk("beq_taken", 32'(branch_tk), 32'd1);
    drive({6'h04, 26'd0}, 4'd1, 1'b1, 1'b0, 32'd5, 32'd6);
    chk("beq_nt_result", alu_result, 32'hFFFF_FFFF);
    chk("beq_nt_flags", 32'(flags), 32'h32);
    chk("beq_nt_taken", 32'(branch_tk), 32'd0);
    drive({6'h05, 26'd0}, 4'd1, 1'b1, 1'b0, 32'd5, 32'd6);
    chk("bne_cond", 32'(cond), 32'd3);
    chk("bne_taken", 32'(branch_tk), 32'd1);

    // REGIMM LT/GE, BLEZ, BGTZ
    drive({6'h01, 26'd0}, 4'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("blt_cond", 32'(cond), 32'd4);
    chk("blt_taken", 32'(branch_tk), 32'd1);
    drive({6'h01, 9'd0, 1'b1, 16'd0}, 4'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("bge_cond", 32'(cond), 32'd5);
    chk("bge_taken", 32'(branch_tk), 32'd0);
    drive({6'h06, 26'd0}, 4'd1, 1'b1, 1'b0, 32'd2, 32'd2);
    chk("ble_cond", 32'(cond), 32'd6);
    chk("ble_taken", 32'(branch_tk), 32'd1);
    drive({6'h07, 26'd0}, 4'd1, 1'b1, 1'b0, 32'd3, 32'd2);
    chk("bgt_cond", 32'(cond), 32'd7);
    chk("bgt_taken", 32'(branch_tk), 32'd1);
    drive({6'h07, 26'd0}, 4'd1, 1'b0, 1'b0, 32'd3, 32'd2);
    chk("bgt_nobranch", 32'(branch_tk), 32'd0);

    // immediate and variable shifts
    drive(rtype(5'd4, 6'h00), 4'd2, 1'b0, 1'b0, 32'h0000_DEAD, 32'd1);
    chk("sll_shift", 32'(shift), 32'd1);
    chk("sll_result", alu_result, 32'h10);
    chk("sll_ctrl", 32'(alu_ctrl), 32'h8);
    drive(rtype(5'd4, 6'h03), 4'd2, 1'b0, 1'b0, 32'h0, 32'h8000_0000);
    chk("sra_result", alu_result, 32'hF800_0000);
    chk("sra_ctrl", 32'(alu_ctrl), 32'hA);
    drive(rtype(5'd0, 6'h06), 4'd2, 1'b0, 1'b0, 32'd4, 32'h8000_0000);
    chk("srlv_shift", 32'(shift), 32'd0);
    chk("srlv_result", alu_result, 32'h0800_0000);

    // register jumps, direct jump
    drive(rtype(5'd0, 6'h09), 4'd2, 1'b1, 1'b0, 32'd5, 32'd5);
    chk("jalr_r2pc", 32'(reg_to_pc), 32'd1);
    chk("jalr_wr", 32'(reg_pc_wr), 32'd1);
    chk("jalr_cond", 32'(cond), 32'd1);
    chk("jalr_jump_tk", 32'(jump_tk), 32'd1);
    chk("jalr_branch_tk", 32'(branch_tk), 32'd0);
    drive(rtype(5'd0, 6'h08), 4'd2, 1'b0, 1'b0, 32'd5, 32'd5);
    chk("jr_r2pc", 32'(reg_to_pc), 32'd1);
    chk("jr_wr", 32'(reg_pc_wr), 32'd0);
    drive(rtype(5'd0, 6'h09), 4'd0, 1'b0, 1'b0, 32'd5, 32'd5);
    chk("jalr_not_rtype", 32'(reg_to_pc), 32'd0);
    drive({6'h04, 26'd0}, 4'd0, 1'b1, 1'b1, 32'd1, 32'd1);
    chk("jump_cond", 32'(cond), 32'd1);
    chk("jump_tk", 32'(jump_tk), 32'd1);
    chk("jump_branch_tk", 32'(branch_tk), 32'd0);

    // assorted functions and defaults
    drive(rtype(5'd0, 6'h27), 4'd2, 1'b0, 1'b0, 32'h0F0F_0F0F, 32'h00FF_00FF);
    chk("nor_result", alu_result, 32'hF000_F000);
    drive(32'h0, 4'd7, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF);
    chk("sltu_result", alu_result, 32'd1);
    drive(32'h0, 4'd6, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF);
    chk("slt_result", alu_result, 32'd0);
    drive(32'h0, 4'd8, 1'b0, 1'b0, 32'h0, 32'h0000_1234);
    chk("lui_result", alu_result, 32'h1234_0000);
    drive(32'h0, 4'd15, 1'b0, 1'b0, 32'd2, 32'd3);
    chk("badop_ctrl", 32'(alu_ctrl), 32'h1);
    chk("badop_result", alu_result, 32'd5);
    drive(rtype(5'd0, 6'h3F), 4'd2, 1'b0, 1'b0, 32'd2, 32'd3);
    chk("badfunct_ctrl", 32'(alu_ctrl), 32'h1);
    chk("badfunct_ctl0", {29'd0, shift, reg_to_pc, reg_pc_wr}, 32'd0);

    // signed overflow on ADD funct
    drive(rtype(5'd0, 6'h20), 4'd2, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1);
    chk("ovf_result", alu_result, 32'h8000_0000);
    chk("ovf_flags", 32'(flags), 32'h0A);
    chk("ovf_trap", 32'(ovf_trap), 32'(TRAP_EN));
    @(posedge CLK); #1;
    chk("ovf_sticky", 32'(ovf_sticky), 32'(TRAP_EN));
    chk("ovf_flags_q", 32'(flags_q), 32'h0A);

    // asynchronous reset mid-cycle
    @(negedge CLK); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_flags_q", 32'(flags_q), 32'h00);
    chk("arst_sticky", 32'(ovf_sticky), 32'h0);
    chk("arst_live_flags", 32'(flags), 32'h0A);
    chk("arst_result", alu_result, 32'h8000_0000);
    chk("arst_trap_masked", 32'(ovf_trap), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge CLK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
